// File: rtl/global_history_reg.sv
// Speculative global branch history with a checkpoint ring for misprediction recovery.
// Latency: ghr_o updates 1 cycle after an accepted predict/recover; ready/id are same-cycle combinational.
// Backpressure: predict_ready_o drops when the ring is full, during recovery, or in reset.
module global_history_reg #(
    parameter int GHR_LENGTH    = 64,
    parameter int CKPT_DEPTH    = 8,
    parameter int CKPT_ID_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     predict_valid_i,
    input  logic                     predict_taken_i,
    output logic                     predict_ready_o,
    output logic [CKPT_ID_WIDTH-1:0] predict_ckpt_id_o,
    input  logic                     commit_valid_i,
    input  logic                     recover_valid_i,
    input  logic [CKPT_ID_WIDTH-1:0] recover_ckpt_id_i,
    input  logic                     recover_taken_i,
    output logic [GHR_LENGTH-1:0]    ghr_o,
    output logic [CKPT_ID_WIDTH:0]   ckpt_count_o
);

    localparam logic [CKPT_ID_WIDTH:0] FULL_COUNT = (CKPT_ID_WIDTH+1)'(CKPT_DEPTH);
    localparam logic [CKPT_ID_WIDTH:0] ONE        = (CKPT_ID_WIDTH+1)'(1);

    logic [GHR_LENGTH-1:0]    ghr;
    logic [GHR_LENGTH-1:0]    ckpt [CKPT_DEPTH];
    logic [CKPT_ID_WIDTH-1:0] head;
    logic [CKPT_ID_WIDTH-1:0] tail;
    logic [CKPT_ID_WIDTH:0]   count;

    logic                     accept;
    logic                     commit_ok;
    logic [CKPT_ID_WIDTH-1:0] rec_dist;
    logic [CKPT_ID_WIDTH:0]   rec_count;
    logic [CKPT_ID_WIDTH:0]   run_count;

    assign predict_ready_o   = !rst && !recover_valid_i && (count != FULL_COUNT);
    assign predict_ckpt_id_o = tail;
    assign accept            = predict_valid_i && predict_ready_o;
    assign commit_ok         = commit_valid_i && (count != '0);

    // Slots from head up to and including the recovered branch stay occupied.
    assign rec_dist  = recover_ckpt_id_i - head;
    assign rec_count = {1'b0, rec_dist} + ONE - {{CKPT_ID_WIDTH{1'b0}}, commit_valid_i};

    always_comb begin
        run_count = count;
        if (accept && !commit_ok) begin
            run_count = count + ONE;
        end else if (!accept && commit_ok) begin
            run_count = count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr   <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (recover_valid_i) begin
            ghr   <= {ckpt[recover_ckpt_id_i][GHR_LENGTH-2:0], recover_taken_i};
            tail  <= recover_ckpt_id_i + 1'b1;
            count <= rec_count;
            if (commit_valid_i) begin
                head <= head + 1'b1;
            end
        end else begin
            if (accept) begin
                ghr  <= {ghr[GHR_LENGTH-2:0], predict_taken_i};
                tail <= tail + 1'b1;
            end
            if (commit_ok) begin
                head <= head + 1'b1;
            end
            count <= run_count;
        end
    end

    // Snapshot storage carries no reset; contents are only read for occupied slots.
    always_ff @(posedge clk) begin
        if (accept) begin
            ckpt[tail] <= ghr;
        end
    end

    assign ghr_o        = ghr;
    assign ckpt_count_o = count;

endmodule

// File: tb/tb_global_history_reg.sv
// Bench for global_history_reg: vector table applied through a scoreboard of next-cycle expectations.
module tb_global_history_reg;

    localparam int L = 8;
    localparam int D = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         predict_valid_i;
    logic         predict_taken_i;
    logic         predict_ready_o;
    logic [W-1:0] predict_ckpt_id_o;
    logic         commit_valid_i;
    logic         recover_valid_i;
    logic [W-1:0] recover_ckpt_id_i;
    logic         recover_taken_i;
    logic [L-1:0] ghr_o;
    logic [W:0]   ckpt_count_o;

    always #5 clk = ~clk;

    global_history_reg #(.GHR_LENGTH(L), .CKPT_DEPTH(D), .CKPT_ID_WIDTH(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .predict_valid_i   (predict_valid_i),
        .predict_taken_i   (predict_taken_i),
        .predict_ready_o   (predict_ready_o),
        .predict_ckpt_id_o (predict_ckpt_id_o),
        .commit_valid_i    (commit_valid_i),
        .recover_valid_i   (recover_valid_i),
        .recover_ckpt_id_i (recover_ckpt_id_i),
        .recover_taken_i   (recover_taken_i),
        .ghr_o             (ghr_o),
        .ckpt_count_o      (ckpt_count_o)
    );

    typedef struct {
        bit         r, pv, pt, cv, rv;
        bit [W-1:0] rid;
        bit         rt;
        bit         e_rdy;
        bit [W-1:0] e_id;
        bit [L-1:0] e_ghr;
        bit [W:0]   e_cnt;
    } vec_t;

    typedef struct {
        bit [L-1:0] ghr;
        bit [W:0]   cnt;
        int         idx;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit [W-1:0] m_head  = '0;
    bit [W:0]   m_cnt   = '0;

    function automatic vec_t mk(input bit r, input bit pv, input bit pt, input bit cv,
                                input bit rv, input bit [W-1:0] rid, input bit rt,
                                input bit e_rdy, input bit [W-1:0] e_id,
                                input bit [L-1:0] e_ghr, input bit [W:0] e_cnt);
        vec_t v;
        v.r = r; v.pv = pv; v.pt = pt; v.cv = cv; v.rv = rv; v.rid = rid; v.rt = rt;
        v.e_rdy = e_rdy; v.e_id = e_id; v.e_ghr = e_ghr; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        rst               = v.r;
        predict_valid_i   = v.pv;
        predict_taken_i   = v.pt;
        commit_valid_i    = v.cv;
        recover_valid_i   = v.rv;
        recover_ckpt_id_i = v.rid;
        recover_taken_i   = v.rt;
        #2;
        // Recovery ids must lie inside the occupied window [head, tail).
        assert (!v.rv || v.r || ({1'b0, W'(v.rid - m_head)} < m_cnt))
            else $error("illegal recovery id %0d in vec %0d", v.rid, idx);
        check("predict_ready", idx, 32'(predict_ready_o), 32'(v.e_rdy));
        check("predict_ckpt_id", idx, 32'(predict_ckpt_id_o), 32'(v.e_id));
        sb.push_back('{ghr: v.e_ghr, cnt: v.e_cnt, idx: idx});
        if (v.r) m_head = '0;
        else if (v.cv && (v.rv || m_cnt != 0)) m_head = m_head + 1'b1;
        m_cnt = v.e_cnt;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", idx, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("ghr", e.idx, 32'(ghr_o), 32'(e.ghr));
            check("ckpt_count", e.idx, 32'(ckpt_count_o), 32'(e.cnt));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; predict_valid_i = 1'b0; predict_taken_i = 1'b0; commit_valid_i = 1'b0;
        recover_valid_i = 1'b0; recover_ckpt_id_i = '0; recover_taken_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", -1, 32'(predict_ready_o), 32'd0);
        check("reset_ghr", -1, 32'(ghr_o), 32'd0);
        check("reset_count", -1, 32'(ckpt_count_o), 32'd0);

        //            r pv pt cv rv rid rt  rdy id ghr    cnt
        // three predictions T, N, T
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0, 8'h01, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 1, 8'h02, 2));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 2, 8'h05, 3));
        // recover id 1 taken: snapshot 0x01 -> 0x03
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1,  0, 3, 8'h03, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 2, 8'h03, 2));
        // recover with same-cycle predict: only recovery lands
        vecs.push_back(mk(0, 1, 1, 0, 1, 1, 0,  0, 2, 8'h02, 2));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 2, 8'h02, 2));
        // fill the ring, then a rejected 5th request
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 2, 8'h05, 3));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 3, 8'h0A, 4));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  0, 0, 8'h0A, 4));
        // commit alone frees a slot; no same-cycle bypass
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  0, 0, 8'h0A, 3));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h0A, 3));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 8'h0A, 2));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 8'h0A, 1));
        // head == id == 3 recovery with commit empties the ring
        vecs.push_back(mk(0, 0, 0, 1, 1, 3, 1,  0, 0, 8'h0B, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h0B, 0));
        // commit while empty is ignored
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0,  1, 0, 8'h0B, 0));
        // predict, predict+commit, and shifting out the oldest bit
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 0, 8'h16, 1));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,  1, 1, 8'h2D, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 2, 8'h5B, 2));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0,  1, 3, 8'hB6, 3));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0,  1, 0, 8'h6D, 3));
        // reset with three in flight
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0,  0, 1, 8'h00, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,  1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1, 0, 8'h01, 1));

        foreach (vecs[i]) apply(vecs[i], i);

        check("scoreboard_drained", -1, 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
